mem_responder: RTL and testbench

Memory-side responder for the multi-cycle CPU's data/instruction memory port. Accepts the controller's MemRead/MemWrite requests with an address and write data, and services them from a word-addressed RAM or a small memory-mapped peripheral block (timer, LEDs). Every access completes through a MemReady handshake after a configurable number of wait states, so the controller can stall in its fetch and memory states. Sits between the datapath's address/write-data muxes and the IR/MDR load paths.

---
 rtl/mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the multi-cycle CPU memory port. Services
// MemRead/MemWrite requests from a word-addressed RAM or a small peripheral
// block (timer TH/TL/TCON and an LED register). Every access completes with a
// one-cycle MemReady pulse after WAIT_STATES wait cycles.
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_memRead    read request, held until MemReady
//   i_memWrite   write request, held until MemReady
//   i_address    byte address, stable while a request is held
//   i_writeData  write data, stable while i_memWrite is held
//   o_readData   registered read data, valid with MemReady, held afterwards
//   o_memReady   one-cycle completion pulse
//   o_addrError  high with MemReady when the access was rejected
//   o_led        LED register
//   o_irq        timer interrupt (level)
//
// Memory map:
//   0x0000_0000 + 4k  RAM word k (k < DEPTH_WORDS)
//   0x4000_0000       TH   timer reload
//   0x4000_0004       TL   timer counter
//   0x4000_0008       TCON bit0 enable, bit1 irq enable, bit2 status (W1C)
//   0x4000_000C       LED  bits 7:0

module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_memRead,
   input  logic        i_memWrite,
   input  logic [31:0] i_address,
   input  logic [31:0] i_writeData,
   output logic [31:0] o_readData,
   output logic        o_memReady,
   output logic        o_addrError,
   output logic [7:0]  o_led,
   output logic        o_irq
);

   localparam int IDX_W = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);
   localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [CNT_W-1:0]   r_waitCnt;
   logic               r_isRead;
   logic               r_isWrite;
   logic               r_addrError;
   logic [31:0]        r_readData;
   logic [31:0]        r_th;
   logic [31:0]        r_tl;
   logic [2:0]         r_tcon;
   logic [7:0]         r_led;
   logic [31:0]        r_ram [DEPTH_WORDS];

   logic               w_misaligned;
   logic               w_isRam;
   logic               w_isPeriph;
   logic               w_opRead;
   logic               w_opWrite;
   logic               w_reject;
   logic               w_enterResp;
   logic               w_commit;
   logic               w_wrRam;
   logic               w_wrTh;
   logic               w_wrTl;
   logic               w_wrTcon;
   logic               w_wrLed;
   logic               w_wrap;
   logic [IDX_W-1:0]   w_ramIdx;
   logic [31:0]        w_rdValue;

   // Address decode straight from the pins: the initiator holds the address
   // stable for the whole request, and writes re-sample it at commit.
   assign w_misaligned = |i_address[1:0];
   assign w_isRam      = ({2'b00, i_address[31:2]} < 32'(DEPTH_WORDS));
   assign w_isPeriph   = (i_address[31:4] == 28'h400_0000);
   assign w_ramIdx     = i_address[IDX_W+1:2];

   // In IDLE the op has not been latched yet (WAIT_STATES=0 goes straight to
   // RESP on the sampling edge), so take it from the request lines.
   assign w_opRead  = (r_state == S_IDLE) ? i_memRead  : r_isRead;
   assign w_opWrite = (r_state == S_IDLE) ? i_memWrite : r_isWrite;
   assign w_reject  = w_misaligned | ~(w_isRam | w_isPeriph) | (w_opRead & w_opWrite);

   always_comb begin
      w_rdValue = 32'd0;
      if (w_isRam) begin
         w_rdValue = r_ram[w_ramIdx];
      end else begin
         case (i_address[3:2])
            2'd0:    w_rdValue = r_th;
            2'd1:    w_rdValue = r_tl;
            2'd2:    w_rdValue = {29'd0, r_tcon};
            default: w_rdValue = {24'd0, r_led};
         endcase
      end
   end

   // Next-state logic. Dropping both request lines during WAIT abandons the
   // access without a response; RESP always returns to IDLE so a held request
   // gets at least one idle cycle before it is sampled again.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_memRead || i_memWrite) begin
               w_nextState = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!i_memRead && !i_memWrite) begin
               w_nextState = S_IDLE;
            end else if (r_waitCnt == CNT_W'(WAIT_STATES)) begin
               w_nextState = S_RESP;
            end
         end
         S_RESP:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   assign w_enterResp = (w_nextState == S_RESP);
   assign w_commit    = (r_state == S_RESP) && r_isWrite && !r_addrError;
   assign w_wrRam     = w_commit && w_isRam;
   assign w_wrTh      = w_commit && w_isPeriph && (i_address[3:2] == 2'd0);
   assign w_wrTl      = w_commit && w_isPeriph && (i_address[3:2] == 2'd1);
   assign w_wrTcon    = w_commit && w_isPeriph && (i_address[3:2] == 2'd2);
   assign w_wrLed     = w_commit && w_isPeriph && (i_address[3:2] == 2'd3);
   assign w_wrap      = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);

   // State register, request latch and response capture. Read data and the
   // reject flag are captured on the edge that enters RESP.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_waitCnt   <= '0;
         r_isRead    <= 1'b0;
         r_isWrite   <= 1'b0;
         r_addrError <= 1'b0;
         r_readData  <= 32'd0;
      end else begin
         r_state <= w_nextState;
         if (r_state == S_IDLE) begin
            r_waitCnt <= CNT_W'(1);
            r_isRead  <= i_memRead;
            r_isWrite <= i_memWrite;
         end else if (r_state == S_WAIT) begin
            r_waitCnt <= r_waitCnt + 1'b1;
         end
         if (w_enterResp) begin
            r_addrError <= w_reject;
            if (w_reject) begin
               r_readData <= 32'd0;
            end else if (w_opRead) begin
               r_readData <= w_rdValue;
            end
         end
      end
   end

   // Peripheral registers and timer. A CPU write to TL beats the increment or
   // reload on the same edge; a status set beats a simultaneous W1C.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_th   <= 32'd0;
         r_tl   <= 32'd0;
         r_tcon <= 3'd0;
         r_led  <= 8'd0;
      end else begin
         if (w_wrTh) begin
            r_th <= i_writeData;
         end
         if (w_wrTl) begin
            r_tl <= i_writeData;
         end else if (r_tcon[0]) begin
            r_tl <= w_wrap ? r_th : r_tl + 32'd1;
         end
         if (w_wrTcon) begin
            r_tcon[1:0] <= i_writeData[1:0];
            r_tcon[2]   <= w_wrap | (r_tcon[2] & ~i_writeData[2]);
         end else if (w_wrap) begin
            r_tcon[2] <= 1'b1;
         end
         if (w_wrLed) begin
            r_led <= i_writeData[7:0];
         end
      end
   end

   // RAM is not reset; writes commit on the edge leaving RESP.
   always_ff @(posedge i_clk) begin
      if (w_wrRam) begin
         r_ram[w_ramIdx] <= i_writeData;
      end
   end

   assign o_readData  = r_readData;
   assign o_memReady  = (r_state == S_RESP);
   assign o_addrError = (r_state == S_RESP) && r_addrError;
   assign o_led       = r_led;
   assign o_irq       = r_tcon[2] & r_tcon[1];

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Drives three mem_responder instances (WAIT_STATES = 0, 1 and 3) that share
// clock, reset, address and write data; the request lines are steered to one
// instance at a time by sel. Bench code always runs 1 time unit after a rising
// edge, so inputs change and outputs are sampled away from the active edge.

module tb_mem_responder;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED  = 32'h4000_000C;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chkData;
      logic [31:0] expData;
      bit          expErr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] writeData = 32'd0;
   logic [1:0]  sel = 2'd1;

   logic [31:0] rd0, rd1, rd3;
   logic        rdy0, rdy1, rdy3;
   logic        err0, err1, err3;
   logic [7:0]  led0, led1, led3;
   logic        irq0, irq1, irq3;

   logic [31:0] curData;
   logic        curReady;
   logic        curErr;

   int compareCount = 0;
   int mismatchCount = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_memRead(memRead && (sel == 2'd0)), .i_memWrite(memWrite && (sel == 2'd0)),
      .i_address(address), .i_writeData(writeData),
      .o_readData(rd0), .o_memReady(rdy0), .o_addrError(err0), .o_led(led0), .o_irq(irq0)
   );

   mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_memRead(memRead && (sel == 2'd1)), .i_memWrite(memWrite && (sel == 2'd1)),
      .i_address(address), .i_writeData(writeData),
      .o_readData(rd1), .o_memReady(rdy1), .o_addrError(err1), .o_led(led1), .o_irq(irq1)
   );

   mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_memRead(memRead && (sel == 2'd3)), .i_memWrite(memWrite && (sel == 2'd3)),
      .i_address(address), .i_writeData(writeData),
      .o_readData(rd3), .o_memReady(rdy3), .o_addrError(err3), .o_led(led3), .o_irq(irq3)
   );

   // Outputs of whichever instance currently owns the request lines.
   always_comb begin
      curData  = rd1;
      curReady = rdy1;
      curErr   = err1;
      case (sel)
         2'd0: begin curData = rd0; curReady = rdy0; curErr = err0; end
         2'd3: begin curData = rd3; curReady = rdy3; curErr = err3; end
         default: ;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compareCount++;
      if (act !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One complete access: raise the request, wait for MemReady (bounded),
   // hold through the commit edge, check the pulse is a single cycle, release.
   task automatic applyStimulus(input string name, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int expLat,
                                output logic [31:0] rdata, output logic err);
      int lat;
      memRead   = rd;
      memWrite  = wr;
      address   = addr;
      writeData = wdata;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!curReady && lat < 20);
      checkOutput({name, " latency"}, lat, expLat);
      rdata = curData;
      err   = curErr;
      @(posedge clk);
      #1;
      checkOutput({name, " pulse width"}, {31'd0, curReady}, 32'd0);
      memRead  = 1'b0;
      memWrite = 1'b0;
   endtask

   function automatic vec_t mkVec(bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                                  bit chkData, logic [31:0] expData, bit expErr);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.chkData = chkData; v.expData = expData; v.expErr = expErr;
      return v;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs[$];
      logic [31:0] rdata;
      logic        err;
      bit          sawReady;

      vecs.push_back(mkVec(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         0));
      vecs.push_back(mkVec(1, 0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF, 0));
      vecs.push_back(mkVec(0, 1, 32'h0000_0020, 32'h1234_5678, 0, 32'h0,         0));
      vecs.push_back(mkVec(1, 0, 32'h0000_0012, 32'h0,         1, 32'h0,         1));
      vecs.push_back(mkVec(1, 0, 32'h2000_0000, 32'h0,         1, 32'h0,         1));
      vecs.push_back(mkVec(1, 1, 32'h0000_0020, 32'hFFFF_FFFF, 1, 32'h0,         1));
      vecs.push_back(mkVec(1, 0, 32'h0000_0020, 32'h0,         1, 32'h1234_5678, 0));
      vecs.push_back(mkVec(0, 1, 32'h0000_03FC, 32'hCAFE_F00D, 0, 32'h0,         0));
      vecs.push_back(mkVec(1, 0, 32'h0000_03FC, 32'h0,         1, 32'hCAFE_F00D, 0));
      vecs.push_back(mkVec(1, 0, 32'h0000_0400, 32'h0,         1, 32'h0,         1));
      vecs.push_back(mkVec(0, 1, 32'h4000_0010, 32'h1,         0, 32'h0,         1));
      vecs.push_back(mkVec(1, 0, 32'h4000_0001, 32'h0,         1, 32'h0,         1));
      vecs.push_back(mkVec(0, 1, A_LED,         32'h1234_56A5, 0, 32'h0,         0));
      vecs.push_back(mkVec(1, 0, A_LED,         32'h0,         1, 32'h0000_00A5, 0));
      vecs.push_back(mkVec(0, 1, A_TCON,        32'hFFFF_FFFA, 0, 32'h0,         0));
      vecs.push_back(mkVec(1, 0, A_TCON,        32'h0,         1, 32'h0000_0002, 0));
      vecs.push_back(mkVec(0, 1, A_TH,          32'hFFFF_FFF0, 0, 32'h0,         0));
      vecs.push_back(mkVec(1, 0, A_TH,          32'h0,         1, 32'hFFFF_FFF0, 0));
      vecs.push_back(mkVec(0, 1, A_TL,          32'hFFFF_FFFE, 0, 32'h0,         0));
      vecs.push_back(mkVec(1, 0, A_TL,          32'h0,         1, 32'hFFFF_FFFE, 0));

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset readData", rd1, 32'd0);
      checkOutput("reset memReady", {31'd0, rdy1}, 32'd0);
      checkOutput("reset addrError", {31'd0, err1}, 32'd0);
      checkOutput("reset led", {24'd0, led1}, 32'd0);
      checkOutput("reset irq", {31'd0, irq1}, 32'd0);
      checkOutput("reset memReady ws0", {31'd0, rdy0}, 32'd0);
      checkOutput("reset memReady ws3", {31'd0, rdy3}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors on the WAIT_STATES=1 instance.
      sel = 2'd1;
      foreach (vecs[i]) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                       vecs[i].wdata, 2, rdata, err);
         checkOutput($sformatf("vec%0d addrError", i), {31'd0, err}, {31'd0, vecs[i].expErr});
         if (vecs[i].chkData) begin
            checkOutput($sformatf("vec%0d readData", i), rdata, vecs[i].expData);
         end
      end
      checkOutput("led pins", {24'd0, led1}, 32'h0000_00A5);

      // Timer: TH=FFFFFFF0, TL=FFFFFFFE already loaded; enable with irq.
      applyStimulus("tcon enable", 0, 1, A_TCON, 32'h3, 2, rdata, err);
      @(posedge clk);
      #1;
      checkOutput("irq before wrap", {31'd0, irq1}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("irq after wrap", {31'd0, irq1}, 32'd1);
      applyStimulus("tl after wrap", 1, 0, A_TL, 32'h0, 2, rdata, err);
      checkOutput("tl reloaded value", rdata, 32'hFFFF_FFF1);

      // Time the W1C commit onto the next wrap edge: status must stay set.
      repeat (10) @(posedge clk);
      #1;
      applyStimulus("w1c on wrap", 0, 1, A_TCON, 32'h7, 2, rdata, err);
      checkOutput("irq w1c on wrap", {31'd0, irq1}, 32'd1);
      applyStimulus("w1c off wrap", 0, 1, A_TCON, 32'h7, 2, rdata, err);
      checkOutput("irq w1c off wrap", {31'd0, irq1}, 32'd0);

      // CPU write to TL wins over the running increment.
      applyStimulus("tl write running", 0, 1, A_TL, 32'h0000_0100, 2, rdata, err);
      applyStimulus("tl read running", 1, 0, A_TL, 32'h0, 2, rdata, err);
      checkOutput("tl write wins", rdata, 32'h0000_0101);

      // WAIT_STATES=3: abandoned write leaves RAM untouched.
      sel = 2'd3;
      applyStimulus("ws3 write 0x40", 0, 1, 32'h0000_0040, 32'h1111_2222, 4, rdata, err);
      address   = 32'h0000_0040;
      writeData = 32'h9999_9999;
      memWrite  = 1'b1;
      sawReady  = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (rdy3) sawReady = 1'b1;
      end
      memWrite = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (rdy3) sawReady = 1'b1;
      end
      checkOutput("abort no memReady", {31'd0, sawReady}, 32'd0);
      applyStimulus("ws3 read 0x40", 1, 0, 32'h0000_0040, 32'h0, 4, rdata, err);
      checkOutput("abort ram unchanged", rdata, 32'h1111_2222);

      // Reset in the middle of an LED write.
      applyStimulus("ws3 led 3c", 0, 1, A_LED, 32'h3C, 4, rdata, err);
      checkOutput("ws3 led set", {24'd0, led3}, 32'h0000_003C);
      address   = A_LED;
      writeData = 32'hA5;
      memWrite  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset led", {24'd0, led3}, 32'd0);
      checkOutput("midreset memReady", {31'd0, rdy3}, 32'd0);
      memWrite = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus("post reset led read", 1, 0, A_LED, 32'h0, 4, rdata, err);
      checkOutput("post reset led value", rdata, 32'd0);
      checkOutput("post reset addrError", {31'd0, err}, 32'd0);

      // WAIT_STATES=0: a held read is serviced every other cycle.
      sel = 2'd0;
      applyStimulus("ws0 write", 0, 1, 32'h0000_0010, 32'h0BAD_CAFE, 1, rdata, err);
      address = 32'h0000_0010;
      memRead = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("ws0 held cycle%0d memReady", c), {31'd0, rdy0}, {31'd0, c[0]});
         if (c[0]) begin
            checkOutput($sformatf("ws0 held cycle%0d readData", c), rd0, 32'h0BAD_CAFE);
         end
      end
      memRead = 1'b0;
      @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
